// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and helpers for the instruction fetch stage.
package if_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] INST_NOP   = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_INC     = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction ROM read bus: req/gnt issue phase, in-order rvalid response phase.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic              rom_req_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_gnt_i;
    logic              rom_rvalid_i;
    logic [INST_W-1:0] rom_rdata_i;

    modport master (
        output rom_req_o,
        output rom_addr_o,
        input  rom_gnt_i,
        input  rom_rvalid_i,
        input  rom_rdata_i
    );

    modport slave (
        input  rom_req_o,
        input  rom_addr_o,
        output rom_gnt_i,
        output rom_rvalid_i,
        output rom_rdata_i
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO with flush; head entry is a direct view of storage.
module if_fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop so the FIFO can never over- or under-run.
    always_comb begin
        pop_ok_s  = pop && (count_r != {CW{1'b0}});
        push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
        count     = count_r;
        head_data = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC ownership, credit-limited ROM reads, in-order
// instruction buffer, and redirect handling with discard of stale responses.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_if.master        bus,
    input  logic              ex_jump_ena_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              hold_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int            LW      = CW + 1;
    localparam int            EW      = ADDR_W + INST_W;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [ADDR_W-1:0] pc_r;
    logic [CW-1:0]     discard_r;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     outstanding_s;
    logic [ADDR_W-1:0] pend_addr_s;
    logic [EW-1:0]     head_s;
    logic [LW-1:0]     level_s;
    logic              pop_s;
    logic              resp_s;
    logic              keep_s;
    logic              credit_ok_s;
    logic              req_s;
    logic              issue_s;

    // Credit accounting: buffered + in-flight (including to-be-discarded) words
    // may never exceed the buffer depth, so a returning word always has a slot.
    always_comb begin
        pop_s       = (count_s != {CW{1'b0}}) && !hold_i;
        resp_s      = bus.rom_rvalid_i && (outstanding_s != {CW{1'b0}});
        keep_s      = resp_s && (discard_r == {CW{1'b0}}) && !ex_jump_ena_i;
        level_s     = LW'(count_s) + LW'(outstanding_s) - LW'(pop_s);
        credit_ok_s = level_s < DEPTH_L;
        req_s       = !rst && credit_ok_s && !ex_jump_ena_i;
        issue_s     = req_s && bus.rom_gnt_i;
    end

    // Bus request and head-of-buffer presentation; empty buffer shows a NOP.
    always_comb begin
        bus.rom_req_o  = req_s;
        bus.rom_addr_o = pc_r;
        if (count_s != {CW{1'b0}}) begin
            inst_valid_o = 1'b1;
            inst_o       = head_s[INST_W-1:0];
            inst_addr_o  = head_s[EW-1:INST_W];
        end else begin
            inst_valid_o = 1'b0;
            inst_o       = INST_NOP;
            inst_addr_o  = ZERO_WORD;
        end
    end

    // PC and discard counter; a redirect overrides issue and marks every
    // still-outstanding response (after this cycle's arrival) as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            discard_r <= {CW{1'b0}};
        end else if (ex_jump_ena_i) begin
            pc_r      <= word_align(ex_jump_addr_i);
            discard_r <= outstanding_s - CW'(resp_s);
        end else begin
            if (issue_s) begin
                pc_r <= pc_r + PC_INC;
            end
            if (resp_s && (discard_r != {CW{1'b0}})) begin
                discard_r <= discard_r - CNT_ONE;
            end
        end
    end

    // Addresses of issued reads, matched in order against returning data.
    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_pend_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (issue_s),
        .push_data (pc_r),
        .pop       (resp_s),
        .count     (outstanding_s),
        .head_data (pend_addr_s)
    );

    // Fetched {addr, inst} pairs waiting for decode.
    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (ex_jump_ena_i),
        .push      (keep_s),
        .push_data ({pend_addr_s, bus.rom_rdata_i}),
        .pop       (pop_s && !ex_jump_ena_i),
        .count     (count_s),
        .head_data (head_s)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a behavioural in-order ROM responder.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        hold = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    bit lat_rand = 1'b0;
    bit gnt_rand = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rom_ent_t;
    rom_ent_t rom_q[$];

    if_fetch_if bus();

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .ex_jump_ena_i  (jump),
        .ex_jump_addr_i (jump_addr),
        .hold_i         (hold),
        .inst_valid_o   (inst_valid),
        .inst_o         (inst),
        .inst_addr_o    (inst_addr)
    );

    always #5 clk = ~clk;

    // ROM responder: in-order, latency lat (or random 1..3) cycles after issue.
    always @(posedge clk) begin
        if (rst) begin
            rom_q.delete();
            bus.rom_rvalid_i <= 1'b0;
            bus.rom_rdata_i  <= 32'h0;
        end else begin
            if (bus.rom_req_o && bus.rom_gnt_i)
                rom_q.push_back('{addr: bus.rom_addr_o,
                                  due: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat)});
            if (rom_q.size() != 0 && rom_q[0].due <= cyc + 1) begin
                bus.rom_rvalid_i <= 1'b1;
                bus.rom_rdata_i  <= rom_q[0].addr ^ 32'hA5A5_0000;
                void'(rom_q.pop_front());
            end else begin
                bus.rom_rvalid_i <= 1'b0;
                bus.rom_rdata_i  <= 32'h0;
            end
        end
        bus.rom_gnt_i <= gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc <= cyc + 1;
    end

    // Two reset cycles; returns inside the first cycle after release (c0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; jump = 1'b0; hold = 1'b0; jump_addr = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; jump = 1'b0; hold = 1'b0;
        @(negedge clk); #1;
        total++; if (bus.rom_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.rom_req_o); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst: got %h want 00000013", inst); end
        total++; if (inst_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", inst_addr); end
        @(negedge clk);
        rst = 1'b0; #1;
        total++; if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h0) begin
            bad++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/00000000", bus.rom_req_o, bus.rom_addr_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        lat = 1; gnt_rand = 1'b0; lat_rand = 1'b0;
        do_reset(); #1;
        total++; if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h0) begin
            bad++; $display("FAIL stream_first_req: got req=%b addr=%h want 1/0", bus.rom_req_o, bus.rom_addr_o); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_no_bypass: got valid=%b want 0", inst_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            exp = 32'(k * 4);
            total++; if (inst_valid !== 1'b1 || inst_addr !== exp || inst !== (exp ^ 32'hA5A5_0000)) begin
                bad++; $display("FAIL stream_out: got v=%b a=%h i=%h want 1/%h/%h", inst_valid, inst_addr, inst, exp, exp ^ 32'hA5A5_0000); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] exp;
        lat = 1;
        do_reset();
        @(negedge clk);
        @(negedge clk); #1;
        total++; if (inst_addr !== 32'h0) begin bad++; $display("FAIL hold_pre0: got %h want 0", inst_addr); end
        @(negedge clk); #1;
        total++; if (inst_addr !== 32'h4) begin bad++; $display("FAIL hold_pre4: got %h want 4", inst_addr); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            hold = 1'b1; #1;
            total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h8 || inst !== 32'hA5A5_0008 || bus.rom_req_o !== 1'b0) begin
                bad++; $display("FAIL hold_frozen: got v=%b a=%h i=%h req=%b want 1/8/a5a50008/0", inst_valid, inst_addr, inst, bus.rom_req_o); end
        end
        @(negedge clk);
        hold = 1'b0; #1;
        total++; if (inst_addr !== 32'h8 || bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h10) begin
            bad++; $display("FAIL hold_resume: got a=%h req=%b raddr=%h want 8/1/10", inst_addr, bus.rom_req_o, bus.rom_addr_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            exp = 32'hC + 32'(k * 4);
            total++; if (inst_valid !== 1'b1 || inst_addr !== exp) begin
                bad++; $display("FAIL hold_after: got v=%b a=%h want 1/%h", inst_valid, inst_addr, exp); end
        end
    endtask

    task automatic test_jump();
        lat = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        jump = 1'b1; jump_addr = 32'h0000_0103; #1;
        total++; if (bus.rom_req_o !== 1'b0) begin bad++; $display("FAIL jump_req_blocked: got %b want 0", bus.rom_req_o); end
        @(negedge clk);
        jump = 1'b0; jump_addr = 32'h0; #1;
        total++; if (bus.rom_req_o !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL jump_drain: got req=%b v=%b want 0/0", bus.rom_req_o, inst_valid); end
        @(negedge clk); #1;
        total++; if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h100) begin
            bad++; $display("FAIL jump_target_req: got req=%b addr=%h want 1/100", bus.rom_req_o, bus.rom_addr_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL jump_stale: got v=%b a=%h want 0", inst_valid, inst_addr); end
        end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h100 || inst !== 32'hA5A5_0100) begin
            bad++; $display("FAIL jump_first: got v=%b a=%h i=%h want 1/100/a5a50100", inst_valid, inst_addr, inst); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h104) begin
            bad++; $display("FAIL jump_second: got v=%b a=%h want 1/104", inst_valid, inst_addr); end
    endtask

    task automatic test_back_to_back();
        lat = 2;
        do_reset();
        repeat (4) @(negedge clk);
        jump = 1'b1; jump_addr = 32'h40; #1;
        total++; if (bus.rom_req_o !== 1'b0) begin bad++; $display("FAIL b2b_req0: got %b want 0", bus.rom_req_o); end
        @(negedge clk);
        jump_addr = 32'h80; #1;
        total++; if (bus.rom_req_o !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_second: got req=%b v=%b want 0/0", bus.rom_req_o, inst_valid); end
        @(negedge clk);
        jump = 1'b0; jump_addr = 32'h0; #1;
        total++; if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h80 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_req80: got req=%b addr=%h v=%b want 1/80/0", bus.rom_req_o, bus.rom_addr_o, inst_valid); end
        @(negedge clk); #1;
        total++; if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h84 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_req84: got req=%b addr=%h v=%b want 1/84/0", bus.rom_req_o, bus.rom_addr_o, inst_valid); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got v=%b a=%h want 0", inst_valid, inst_addr); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h80) begin
            bad++; $display("FAIL b2b_first: got v=%b a=%h want 1/80", inst_valid, inst_addr); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h84) begin
            bad++; $display("FAIL b2b_next: got v=%b a=%h want 1/84", inst_valid, inst_addr); end
    endtask

    task automatic test_reset_mid();
        lat = 1;
        do_reset();
        repeat (4) @(negedge clk);
        rst = 1'b1; #1;
        total++; if (bus.rom_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_req: got %b want 0", bus.rom_req_o); end
        @(negedge clk);
        rst = 1'b0; #1;
        total++; if (inst_valid !== 1'b0 || inst !== 32'h13 || inst_addr !== 32'h0) begin
            bad++; $display("FAIL rstmid_out: got v=%b i=%h a=%h want 0/13/0", inst_valid, inst, inst_addr); end
        total++; if (bus.rom_req_o !== 1'b1 || bus.rom_addr_o !== 32'h0) begin
            bad++; $display("FAIL rstmid_first_req: got req=%b addr=%h want 1/0", bus.rom_req_o, bus.rom_addr_o); end
        @(negedge clk);
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst !== 32'hA5A5_0000) begin
            bad++; $display("FAIL rstmid_first_out: got v=%b a=%h i=%h want 1/0/a5a50000", inst_valid, inst_addr, inst); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int          n;
        gnt_rand = 1'b1; lat_rand = 1'b1;
        do_reset();
        exp = 32'h0; n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            hold = ($urandom_range(0, 3) == 0); #1;
            total++; if (rom_q.size() > 2) begin bad++; $display("FAIL rand_credit: got %0d in flight want <=2", rom_q.size()); end
            if (inst_valid && !hold) begin
                total++; if (inst_addr !== exp || inst !== (exp ^ 32'hA5A5_0000)) begin
                    bad++; $display("FAIL rand_order: got a=%h i=%h want %h/%h", inst_addr, inst, exp, exp ^ 32'hA5A5_0000); end
                exp = exp + 32'h4; n++;
            end
        end
        total++; if (n < 40) begin bad++; $display("FAIL rand_progress: got %0d insts want >=40", n); end
        hold = 1'b0; gnt_rand = 1'b0; lat_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_jump();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
